cpu_ad48_run_ctrl: RTL and testbench

Run controller for the `cpu_ad48` core. It zero-fills and then loads instruction memory from a 48-bit valid/ready stream, holding the core in reset while it does so. It then releases the core, counts cycles until `halt`, and reports completion, cycle count and error status. It sits between a host/loader port and the core's IMEM write port and core reset.

---
 rtl/cpu_ad48_run_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cpu_ad48_run_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ad48_run_ctrl.sv
// rtl/cpu_ad48_run_ctrl.sv - IMEM clear/load, core reset hold, run cycle counting for cpu_ad48
module cpu_ad48_run_ctrl #(
  parameter int IM_WORDS = 128,
  parameter int IM_AW    = 7,
  parameter int RST_HOLD = 4,
  parameter int TIMEOUT  = 4096,
  parameter int CW       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [47:0]      ld_data,
  input  logic             ld_last,
  output logic             im_we,
  output logic [IM_AW-1:0] im_waddr,
  output logic [47:0]      im_wdata,
  output logic             core_resetn,
  input  logic             core_halt,
  output logic             busy,
  output logic             done,
  output logic             err_ovf,
  output logic             err_tmo,
  output logic [CW-1:0]    cycles,
  output logic [IM_AW:0]   words
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

  localparam int HW = $clog2(RST_HOLD) + 1;
  localparam logic [IM_AW-1:0] LAST_ADDR = IM_AW'(IM_WORDS - 1);
  localparam logic [IM_AW:0]   LAST_WORD = (IM_AW + 1)'(IM_WORDS - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [CW-1:0]    TMO_VAL   = CW'(TIMEOUT);

  state_t             state_q, state_d;
  logic               ld_ready_q, ld_ready_d;
  logic               im_we_q, im_we_d;
  logic [IM_AW-1:0]   im_waddr_q, im_waddr_d;
  logic [47:0]        im_wdata_q, im_wdata_d;
  logic               core_resetn_q, core_resetn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_tmo_q, err_tmo_d;
  logic [CW-1:0]      cycles_q, cycles_d;
  logic [IM_AW:0]     words_q, words_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;

  // Next-state and next-output logic; the load address is the running word count.
  always_comb begin
    state_d       = state_q;
    ld_ready_d    = ld_ready_q;
    im_we_d       = 1'b0;
    im_waddr_d    = im_waddr_q;
    im_wdata_d    = im_wdata_q;
    core_resetn_d = core_resetn_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_ovf_d     = err_ovf_q;
    err_tmo_d     = err_tmo_q;
    cycles_d      = cycles_q;
    words_d       = words_q;
    hold_cnt_d    = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        core_resetn_d = 1'b0;
        busy_d        = 1'b0;
        ld_ready_d    = 1'b0;
        if (start) begin
          state_d    = S_CLEAR;
          busy_d     = 1'b1;
          im_we_d    = 1'b1;
          im_waddr_d = '0;
          im_wdata_d = '0;
          err_ovf_d  = 1'b0;
          err_tmo_d  = 1'b0;
          cycles_d   = '0;
          words_d    = '0;
        end
      end
      S_CLEAR: begin
        if (im_waddr_q == LAST_ADDR) begin
          state_d    = S_LOAD;
          ld_ready_d = 1'b1;
        end else begin
          im_we_d    = 1'b1;
          im_waddr_d = im_waddr_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          im_we_d    = 1'b1;
          im_waddr_d = words_q[IM_AW-1:0];
          im_wdata_d = ld_data;
          words_d    = words_q + 1'b1;
          if (ld_last) begin
            state_d    = S_HOLD;
            ld_ready_d = 1'b0;
            hold_cnt_d = '0;
          end else if (words_q == LAST_WORD) begin
            state_d    = S_DONE;
            ld_ready_d = 1'b0;
            err_ovf_d  = 1'b1;
            done_d     = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d       = S_RUN;
          core_resetn_d = 1'b1;
          cycles_d      = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // Halt is tested first so that a halt coinciding with the timeout is not an error.
        if (core_halt) begin
          state_d       = S_DONE;
          done_d        = 1'b1;
          core_resetn_d = 1'b0;
        end else if (cycles_q == TMO_VAL) begin
          state_d       = S_DONE;
          done_d        = 1'b1;
          core_resetn_d = 1'b0;
          err_tmo_d     = 1'b1;
        end else if (cycles_q != '1) begin
          cycles_d = cycles_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; async reset parks the core in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      ld_ready_q    <= 1'b0;
      im_we_q       <= 1'b0;
      im_waddr_q    <= '0;
      im_wdata_q    <= '0;
      core_resetn_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_tmo_q     <= 1'b0;
      cycles_q      <= '0;
      words_q       <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ld_ready_q    <= ld_ready_d;
      im_we_q       <= im_we_d;
      im_waddr_q    <= im_waddr_d;
      im_wdata_q    <= im_wdata_d;
      core_resetn_q <= core_resetn_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_ovf_q     <= err_ovf_d;
      err_tmo_q     <= err_tmo_d;
      cycles_q      <= cycles_d;
      words_q       <= words_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign ld_ready    = ld_ready_q;
  assign im_we       = im_we_q;
  assign im_waddr    = im_waddr_q;
  assign im_wdata    = im_wdata_q;
  assign core_resetn = core_resetn_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_ovf     = err_ovf_q;
  assign err_tmo     = err_tmo_q;
  assign cycles      = cycles_q;
  assign words       = words_q;

endmodule

// File: tb/tb_cpu_ad48_run_ctrl.sv
// tb/tb_cpu_ad48_run_ctrl.sv - self-checking bench for cpu_ad48_run_ctrl
module tb_cpu_ad48_run_ctrl;

  localparam int IMW = 128;
  localparam int AW  = 7;
  localparam int RH  = 4;
  localparam int TMO = 64;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [47:0]   ld_data = '0;
  logic          ld_last = 1'b0;
  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [47:0]   im_wdata;
  logic          core_resetn;
  logic          core_halt = 1'b0;
  logic          busy;
  logic          done;
  logic          err_ovf;
  logic          err_tmo;
  logic [CW-1:0] cycles;
  logic [AW:0]   words;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_ad48_run_ctrl #(
    .IM_WORDS(IMW), .IM_AW(AW), .RST_HOLD(RH), .TIMEOUT(TMO), .CW(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .core_resetn(core_resetn), .core_halt(core_halt),
    .busy(busy), .done(done), .err_ovf(err_ovf), .err_tmo(err_tmo),
    .cycles(cycles), .words(words)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [47:0]   d;
  } wr_t;
  wr_t wlog[$];

  // Record every IMEM write, sampled away from the active edge.
  always @(negedge clk) begin
    if (im_we) wlog.push_back('{im_waddr, im_wdata});
  end

  typedef struct {
    string name;
    int    nwords;
    bit    toggle;
    bit    last_en;
    int    halt_at;
    bit    start_in_run;
    int    exp_words;
    int    exp_cycles;
    bit    exp_ovf;
    bit    exp_tmo;
    int    exp_len;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pat(input int s, input int i);
    return {16'hC0DE, s[7:0], i[23:0]};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_ld_ready"}, 64'(ld_ready), 0);
    check({tag, "_im_we"}, 64'(im_we), 0);
    check({tag, "_im_waddr"}, 64'(im_waddr), 0);
    check({tag, "_im_wdata"}, 64'(im_wdata), 0);
    check({tag, "_core_resetn"}, 64'(core_resetn), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_errs"}, 64'({err_ovf, err_tmo}), 0);
    check({tag, "_cycles"}, 64'(cycles), 0);
    check({tag, "_words"}, 64'(words), 0);
  endtask

  task automatic run_session(input vec_t v, input int s);
    int sent = 0;
    int hold = 0;
    int done_k = -1;
    bit tog = 1'b0;
    bit fin = 1'b0;
    bit rst_high = 1'b0;
    bit pulsed = 1'b0;
    int k = 1;
    int errs = 0;
    logic [63:0] f_words = '0, f_cycles = '0, f_ovf = '0, f_tmo = '0;
    wlog.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({v.name, "_busy_after_start"}, 64'(busy), 1);
    while (k <= 3000 && !fin) begin
      if (core_resetn) rst_high = 1'b1;
      if (done) begin
        done_k = k;
        fin = 1'b1;
        f_words = 64'(words);
        f_cycles = 64'(cycles);
        f_ovf = 64'(err_ovf);
        f_tmo = 64'(err_tmo);
      end
      if (busy && !done && !ld_ready && !core_resetn && sent == v.nwords) hold++;
      if (sent < v.nwords && ld_ready) begin
        ld_valid = v.toggle ? ~tog : 1'b1;
        tog = ~tog;
        ld_data = pat(s, sent);
        ld_last = v.last_en && (sent == v.nwords - 1);
        if (ld_valid) sent++;
      end else begin
        ld_valid = 1'b0;
        ld_last = 1'b0;
      end
      core_halt = core_resetn && (v.halt_at >= 0) && (cycles == CW'(v.halt_at));
      if (v.start_in_run && core_resetn && cycles == 5 && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (!fin) begin
        @(negedge clk);
        k++;
      end
    end
    core_halt = 1'b0;
    start = 1'b0;
    check({v.name, "_done_seen"}, 64'(fin), 1);
    check({v.name, "_words"}, f_words, 64'(v.exp_words));
    check({v.name, "_cycles"}, f_cycles, 64'(v.exp_cycles));
    check({v.name, "_err_ovf"}, f_ovf, 64'(v.exp_ovf));
    check({v.name, "_err_tmo"}, f_tmo, 64'(v.exp_tmo));
    check({v.name, "_core_released"}, 64'(rst_high), 64'(!v.exp_ovf));
    if (!v.exp_ovf) check({v.name, "_hold_cycles"}, 64'(hold), 64'(RH));
    if (v.exp_len >= 0) check({v.name, "_session_len"}, 64'(done_k), 64'(v.exp_len));
    @(negedge clk);
    check({v.name, "_done_one_cycle"}, 64'(done), 0);
    check({v.name, "_busy_fall"}, 64'(busy), 0);
    check({v.name, "_errs_sticky"}, 64'({err_ovf, err_tmo}), 64'({v.exp_ovf, v.exp_tmo}));
    check({v.name, "_words_hold"}, 64'(words), 64'(v.exp_words));
    check({v.name, "_wr_count"}, 64'(wlog.size()), 64'(IMW + v.nwords));
    for (int i = 0; i < wlog.size() && i < IMW + v.nwords; i++) begin
      if (i < IMW) begin
        if (wlog[i].a !== AW'(i) || wlog[i].d !== 48'h0) errs++;
      end else begin
        if (wlog[i].a !== AW'(i - IMW) || wlog[i].d !== pat(s, i - IMW)) errs++;
      end
    end
    check({v.name, "_wr_content"}, 64'(errs), 0);
  endtask

  initial begin
    int w;
    //          name       n    tog last halt  sir words cyc ovf tmo len
    vecs[0] = '{"nominal",  3,  0,  1,  7,    0,  3,    7,  0,  0,  IMW + 3 + RH + 8 + 1};
    vecs[1] = '{"bp_load",  5,  1,  1,  3,    0,  5,    3,  0,  0,  -1};
    vecs[2] = '{"overflow", IMW, 0, 0,  -1,   0,  IMW,  0,  1,  0,  -1};
    vecs[3] = '{"timeout",  1,  0,  1,  -1,   0,  1,    TMO, 0, 1,  -1};
    vecs[4] = '{"tie",      1,  0,  1,  TMO,  0,  1,    TMO, 0, 0,  -1};
    vecs[5] = '{"start_run", 2, 0,  1,  20,   1,  2,    20, 0,  0,  -1};
    vecs[6] = '{"min_sess", 1,  0,  1,  0,    0,  1,    0,  0,  0,  IMW + 1 + RH + 1 + 1};

    repeat (3) @(negedge clk);
    check_reset_values("por");
    resetn = 1'b1;
    @(negedge clk);

    // Async reset in the middle of LOAD, after two accepted words.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!ld_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("midload_ready_seen", 64'(ld_ready), 1);
    ld_valid = 1'b1;
    ld_data = pat(9, 0);
    @(negedge clk);
    ld_data = pat(9, 1);
    @(negedge clk);
    ld_valid = 1'b0;
    check("midload_words", 64'(words), 2);
    check("midload_we", 64'(im_we), 1);
    #2 resetn = 1'b0;
    #1 check_reset_values("midload_rst");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_session(vecs[i], i + 1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
